// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard unit for a five-stage core.
//
// Tracks a shadow copy of the hazard-relevant fields of the instructions in
// E, M and W. From those copies and the D-stage inputs it produces
// combinational stall, flush and operand-forwarding controls. A small FSM
// counts how long a data-memory access in M has been waiting and flags a
// timeout once that count saturates.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   RS1D/RS2D    in   [4:0] source registers of the D instruction
//   RDD          in   [4:0] destination register of the D instruction
//   RegWriteD    in   D instruction writes RDD
//   MemWriteD    in   D instruction is a store
//   ResultSrcD   in   [1:0] 2'b01 marks a load
//   PCSrcE       in   branch/jump in E is taken
//   mem_ready    in   data memory completes the M access this cycle
//   StallF..M    out  hold PC, D/E, E/M, M/W registers
//   FlushD/E     out  clear F/D and D/E registers
//   ForwardAE/BE out  [1:0] 00 regfile, 01 W result, 10 M ALU result
//   mem_timeout  out  memory wait has saturated
//
// FSM states
//   state | meaning
//   RUN   | no memory wait outstanding, wait_cnt held at 0
//   MWAIT | access in M still waiting, wait_cnt counting up to 15

module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RS1D,
    input  logic [4:0] RS2D,
    input  logic [4:0] RDD,
    input  logic       RegWriteD,
    input  logic       MemWriteD,
    input  logic [1:0] ResultSrcD,
    input  logic       PCSrcE,
    input  logic       mem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mem_timeout
);

    typedef enum logic {RUN, MWAIT} state_t;

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    logic [4:0] e_rs1_q, e_rs1_d;
    logic [4:0] e_rs2_q, e_rs2_d;
    logic [4:0] e_rd_q, e_rd_d;
    logic       e_rw_q, e_rw_d;
    logic       e_ld_q, e_ld_d;
    logic       e_ma_q, e_ma_d;
    logic [4:0] m_rd_q, m_rd_d;
    logic       m_rw_q, m_rw_d;
    logic       m_ma_q, m_ma_d;
    logic [4:0] w_rd_q, w_rd_d;
    logic       w_rw_q, w_rw_d;

    logic       d_ld;
    logic       d_ma;
    logic       mem_stall;
    logic       lu_hazard;

    assign d_ld      = (ResultSrcD == 2'b01);
    assign d_ma      = d_ld | MemWriteD;
    assign mem_stall = m_ma_q & ~mem_ready;
    assign lu_hazard = e_ld_q & (e_rd_q != 5'd0) &
                       ((e_rd_q == RS1D) | (e_rd_q == RS2D));

    // M has priority over W because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] m_rd,
                                           input logic       m_rw,
                                           input logic [4:0] w_rd,
                                           input logic       w_rw);
        logic [1:0] sel;
        sel = 2'b00;
        if (m_rw && (m_rd != 5'd0) && (m_rd == rs))
            sel = 2'b10;
        else if (w_rw && (w_rd != 5'd0) && (w_rd == rs))
            sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = fwd_sel(e_rs1_q, m_rd_q, m_rw_q, w_rd_q, w_rw_q);
        ForwardBE = fwd_sel(e_rs2_q, m_rd_q, m_rw_q, w_rd_q, w_rw_q);
        if (mem_stall) begin
            // A taken branch must wait: flushing now would discard the
            // frozen instructions.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lu_hazard) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        e_rs1_d = e_rs1_q;
        e_rs2_d = e_rs2_q;
        e_rd_d  = e_rd_q;
        e_rw_d  = e_rw_q;
        e_ld_d  = e_ld_q;
        e_ma_d  = e_ma_q;
        m_rd_d  = m_rd_q;
        m_rw_d  = m_rw_q;
        m_ma_d  = m_ma_q;
        w_rd_d  = 5'd0;
        w_rw_d  = 1'b0;
        if (!mem_stall) begin
            w_rd_d = m_rd_q;
            w_rw_d = m_rw_q;
            m_rd_d = e_rd_q;
            m_rw_d = e_rw_q;
            m_ma_d = e_ma_q;
            if (FlushE) begin
                e_rs1_d = 5'd0;
                e_rs2_d = 5'd0;
                e_rd_d  = 5'd0;
                e_rw_d  = 1'b0;
                e_ld_d  = 1'b0;
                e_ma_d  = 1'b0;
            end else begin
                e_rs1_d = RS1D;
                e_rs2_d = RS2D;
                e_rd_d  = RDD;
                e_rw_d  = RegWriteD;
                e_ld_d  = d_ld;
                e_ma_d  = d_ma;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                wait_cnt_d = 4'd0;
                if (mem_stall)
                    state_d = MWAIT;
            end
            MWAIT: begin
                if (!mem_stall) begin
                    state_d    = RUN;
                    wait_cnt_d = 4'd0;
                end else if (wait_cnt_q != 4'd15) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    assign mem_timeout = (state_q == MWAIT) && (wait_cnt_q == 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 4'd0;
            e_rs1_q    <= 5'd0;
            e_rs2_q    <= 5'd0;
            e_rd_q     <= 5'd0;
            e_rw_q     <= 1'b0;
            e_ld_q     <= 1'b0;
            e_ma_q     <= 1'b0;
            m_rd_q     <= 5'd0;
            m_rw_q     <= 1'b0;
            m_ma_q     <= 1'b0;
            w_rd_q     <= 5'd0;
            w_rw_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            e_rs1_q    <= e_rs1_d;
            e_rs2_q    <= e_rs2_d;
            e_rd_q     <= e_rd_d;
            e_rw_q     <= e_rw_d;
            e_ld_q     <= e_ld_d;
            e_ma_q     <= e_ma_d;
            m_rd_q     <= m_rd_d;
            m_rw_q     <= m_rw_d;
            m_ma_q     <= m_ma_d;
            w_rd_q     <= w_rd_d;
            w_rw_q     <= w_rw_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
// Output word compared each cycle:
//   {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, mem_timeout}

module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mw;
        logic [1:0] rsrc;
        logic       pc;
        logic       rdy;
    } vin_t;

    typedef struct {
        vin_t        vi;
        logic [10:0] exp;
    } vec_t;

    typedef struct {
        logic [10:0] exp;
        logic [10:0] mask;
        string       tag;
    } sb_t;

    localparam logic [10:0] O_NONE = 11'b0000_00_00_00_0;
    localparam logic [10:0] O_STL  = 11'b1111_00_00_00_0;
    localparam logic [10:0] O_LU   = 11'b1100_01_00_00_0;
    localparam logic [10:0] O_FL   = 11'b0000_11_00_00_0;
    localparam logic [10:0] O_FA01 = 11'b0000_00_01_00_0;
    localparam logic [10:0] O_FB01 = 11'b0000_00_00_01_0;
    localparam logic [10:0] O_FA10 = 11'b0000_00_10_00_0;
    localparam logic [10:0] O_FB10 = 11'b0000_00_00_10_0;
    localparam logic [10:0] O_TO   = 11'b0000_00_00_00_1;
    localparam logic [10:0] M_ALL  = 11'h7FF;
    localparam logic [10:0] M_NOTO = 11'h7FE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] RS1D = 5'd0, RS2D = 5'd0, RDD = 5'd0;
    logic       RegWriteD = 1'b0, MemWriteD = 1'b0;
    logic [1:0] ResultSrcD = 2'b00;
    logic       PCSrcE = 1'b0, mem_ready = 1'b1;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
    logic [1:0] ForwardAE, ForwardBE;
    logic [10:0] act;

    int vectors = 0;
    int miscompares = 0;
    sb_t sb_q[$];
    vec_t tbl [0:19];

    hazard_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .RS1D       (RS1D),
        .RS2D       (RS2D),
        .RDD        (RDD),
        .RegWriteD  (RegWriteD),
        .MemWriteD  (MemWriteD),
        .ResultSrcD (ResultSrcD),
        .PCSrcE     (PCSrcE),
        .mem_ready  (mem_ready),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    assign act = {StallF, StallD, StallE, StallM, FlushD, FlushE,
                  ForwardAE, ForwardBE, mem_timeout};

    function automatic vin_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic rw,
                                input logic mw, input logic [1:0] rsrc,
                                input logic pc, input logic rdy);
        vin_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw;
        v.mw = mw; v.rsrc = rsrc; v.pc = pc; v.rdy = rdy;
        return v;
    endfunction

    task automatic drive(input vin_t v);
        RS1D = v.rs1; RS2D = v.rs2; RDD = v.rd;
        RegWriteD = v.rw; MemWriteD = v.mw; ResultSrcD = v.rsrc;
        PCSrcE = v.pc; mem_ready = v.rdy;
    endtask

    task automatic push_exp(input logic [10:0] e, input logic [10:0] m,
                            input string tag);
        sb_t s;
        s.exp = e; s.mask = m; s.tag = tag;
        sb_q.push_back(s);
    endtask

    task automatic compare_pop();
        sb_t s;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty: no expectation queued");
        end else begin
            s = sb_q.pop_front();
            vectors++;
            if ((act & s.mask) !== (s.exp & s.mask)) begin
                miscompares++;
                $display("FAIL %s: got %b want %b (mask %b)",
                         s.tag, act, s.exp, s.mask);
            end
        end
    endtask

    // One clock cycle: inputs change just after the rising edge, outputs
    // are sampled on the falling edge.
    task automatic cycle(input vin_t v, input logic [10:0] e,
                         input logic [10:0] m, input string tag);
        @(posedge clk);
        #1;
        drive(v);
        push_exp(e, m, tag);
        @(negedge clk);
        compare_pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vin_t nop;
        vin_t rdy0;
        vin_t subw;
        nop  = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        rdy0 = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Sequential program: each row is one cycle from reset.
        tbl[0]  = '{nop, O_NONE};
        tbl[1]  = '{mk(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1), O_NONE};   // lw x5
        tbl[2]  = '{mk(5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), O_LU};     // add x6,x5,x7
        tbl[3]  = '{mk(5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), O_NONE};   // held add
        tbl[4]  = '{mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), O_FA01};   // add x3; E=add uses W load
        tbl[5]  = '{mk(5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), O_NONE};   // sub x4,x3,x3
        tbl[6]  = '{nop, O_FA10 | O_FB10};
        tbl[7]  = '{mk(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1), O_NONE};   // lw x8
        tbl[8]  = '{mk(5'd9, 5'd8, 5'd10, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1), O_FL};    // taken branch beats load-use
        tbl[9]  = '{nop, O_NONE};
        tbl[10] = '{mk(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), O_NONE};   // write x0
        tbl[11] = '{mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1), O_NONE};   // lw x0
        tbl[12] = '{mk(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), O_NONE};   // read x0 after lw x0
        tbl[13] = '{nop, O_NONE};
        tbl[14] = '{mk(5'd2, 5'd3, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1), O_NONE};   // sw
        tbl[15] = '{nop, O_NONE};
        tbl[16] = '{mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0), O_STL};    // store waits, branch ignored
        tbl[17] = '{rdy0, O_STL};
        tbl[18] = '{nop, O_NONE};
        tbl[19] = '{nop, O_NONE};

        // Outputs during reset, before any clock edge.
        drive(mk(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0));
        #2;
        push_exp(O_NONE, M_ALL, "reset_no_clk");
        compare_pop();
        @(posedge clk);
        @(negedge clk);
        push_exp(O_NONE, M_ALL, "reset_clocked");
        compare_pop();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(nop);
        @(negedge clk);

        for (int i = 0; i < 20; i++)
            cycle(tbl[i].vi, tbl[i].exp, M_ALL, $sformatf("tbl[%0d]", i));

        // Long memory wait: W-forward disappears once W takes bubbles,
        // timeout on the 16th MWAIT cycle.
        subw = mk(5'd7, 5'd7, 5'd9, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        cycle(mk(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), O_NONE, M_ALL, "wait_add7");
        cycle(mk(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1), O_NONE, M_ALL, "wait_lw5");
        cycle(subw, O_NONE, M_ALL, "wait_sub");
        subw.rdy = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            logic [10:0] e;
            e = O_STL;
            if (k == 1)  e = e | O_FA01 | O_FB01;
            if (k >= 17) e = e | O_TO;
            cycle(subw, e, M_ALL, $sformatf("wait_stall[%0d]", k));
        end
        subw.rdy = 1'b1;
        cycle(subw, O_NONE, M_NOTO, "wait_release");
        cycle(nop, O_NONE, M_ALL, "wait_after");

        // Reset in the middle of a saturated wait.
        cycle(mk(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1), O_NONE, M_ALL, "rw_lw5");
        cycle(nop, O_NONE, M_ALL, "rw_nop");
        for (int k = 1; k <= 17; k++)
            cycle(rdy0, (k == 17) ? (O_STL | O_TO) : O_STL, M_ALL,
                  $sformatf("rw_stall[%0d]", k));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        push_exp(O_NONE, M_ALL, "rw_async_reset");
        compare_pop();
        @(negedge clk);
        push_exp(O_NONE, M_ALL, "rw_reset_held");
        compare_pop();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(mk(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1));
        push_exp(O_NONE, M_ALL, "rw_release_lw5");
        @(negedge clk);
        compare_pop();
        cycle(mk(5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1), O_LU, M_ALL, "rw_first_edge_lu");
        cycle(nop, O_NONE, M_ALL, "rw_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
